// File: rtl/seq_pkg.sv
// Shared definitions for the soft-processor sequencer and ALU: opcode and
// funct encodings, FSM state encoding, instruction classes and fault codes.
package seq_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SLL = 6'b000000;

  // Sequencer state encoding
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  typedef enum logic [2:0] {
    FETCH  = S_FETCH,
    DECODE = S_DECODE,
    EXEC   = S_EXEC,
    MEM    = S_MEM,
    WB     = S_WB,
    HALT   = S_HALT
  } state_e;

  // Instruction classes produced by the decoder
  typedef enum logic [1:0] {
    CLS_RTYPE = 2'd0,
    CLS_LW    = 2'd1,
    CLS_SW    = 2'd2,
    CLS_BEQ   = 2'd3
  } instr_class_e;

  // Fault codes
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // True for the R-type function codes the ALU implements
  function automatic logic funct_is_legal(input logic [5:0] f);
    logic ok;
    ok = 1'b0;
    case (f)
      F_ADD, F_SUB, F_AND, F_OR, F_SRL, F_SLL: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: splits the instruction register
// into ALU / register-file fields, sign-extends the immediate, classifies the
// instruction and flags anything the sequencer cannot execute.
import seq_pkg::*;

module instr_decoder (
  input  logic [31:0]  ir,
  output logic [5:0]   opcode,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [4:0]   shamt,
  output logic [5:0]   funct,
  output logic [31:0]  imm,
  output instr_class_e iclass,
  output logic         legal
);

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm    = {{16{ir[15]}}, ir[15:0]};

  // Classify the opcode and decide legality
  always_comb begin
    iclass = CLS_RTYPE;
    legal  = 1'b0;
    case (ir[31:26])
      OP_RTYPE: begin
        iclass = CLS_RTYPE;
        legal  = funct_is_legal(ir[5:0]);
      end
      OP_LW: begin
        iclass = CLS_LW;
        legal  = 1'b1;
      end
      OP_SW: begin
        iclass = CLS_SW;
        legal  = 1'b1;
      end
      OP_BEQ: begin
        iclass = CLS_BEQ;
        legal  = 1'b1;
      end
      default: begin
        iclass = CLS_RTYPE;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle control FSM for the soft processor: fetch, decode, execute,
// memory access and writeback, plus PC update and handshake timeouts.
// All strobes are registered and derived from the next state, so a strobe
// is high exactly while the FSM sits in the state that owns it.
// Optional build macro SEQ_PERF_COUNTERS_EN adds saturating cycle and
// retired-instruction counters on extra output ports.
import seq_pkg::*;

module alu_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [5:0]  alu_opcode,
  output logic [4:0]  alu_shamt,
  output logic [5:0]  alu_funct,
  input  logic        alu_zero,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  rd_addr,
  output logic [31:0] imm,
  output logic        alu_src,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        dmem_re,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        halted,
`ifdef SEQ_PERF_COUNTERS_EN
  output logic [31:0] cycle_count,
  output logic [31:0] retired_count,
`endif
  output logic [1:0]  fault
);

  // Counter terminal value: the wait counter saturates one below the limit,
  // so the limit-th waiting cycle is the last one before a fault.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT) - 8'd1;

  state_e       state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [7:0]   wait_q, wait_d;
  logic [1:0]   fault_q, fault_d;
  logic         imem_req_q, imem_req_d;
  logic         alu_src_q, alu_src_d;
  logic         reg_we_q, reg_we_d;
  logic         wb_sel_q, wb_sel_d;
  logic         dmem_re_q, dmem_re_d;
  logic         dmem_we_q, dmem_we_d;
  logic         halted_q, halted_d;

  instr_class_e iclass;
  logic         legal;
  logic [31:0]  pc_plus4;
  logic         imem_done;
  logic         dmem_done;

  instr_decoder u_dec (
    .ir     (ir_q),
    .opcode (alu_opcode),
    .rs     (rs_addr),
    .rt     (rt_addr),
    .rd     (rd_addr),
    .shamt  (alu_shamt),
    .funct  (alu_funct),
    .imm    (imm),
    .iclass (iclass),
    .legal  (legal)
  );

  assign pc_plus4  = pc_q + 32'd4;
  // A handshake only completes while our own request/strobe is up.
  assign imem_done = imem_req_q && imem_ready;
  assign dmem_done = (dmem_re_q || dmem_we_q) && dmem_ready;

  // Next-state, PC, IR, wait counter and fault computation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    case (state_q)
      FETCH: begin
        if (imem_done) begin
          ir_d    = instr;
          state_d = DECODE;
        end else if (imem_req_q) begin
          if (wait_q == TIMEOUT_LAST) begin
            state_d = HALT;
            fault_d = FAULT_TIMEOUT;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      DECODE: begin
        if (legal) begin
          state_d = EXEC;
        end else begin
          state_d = HALT;
          fault_d = FAULT_ILLEGAL;
        end
      end
      EXEC: begin
        wait_d = 8'd0;
        case (iclass)
          CLS_RTYPE: state_d = WB;
          CLS_LW,
          CLS_SW:    state_d = MEM;
          CLS_BEQ: begin
            pc_d    = alu_zero ? (pc_plus4 + (imm << 2)) : pc_plus4;
            state_d = FETCH;
          end
          default:   state_d = HALT;
        endcase
      end
      MEM: begin
        if (dmem_done) begin
          wait_d = 8'd0;
          if (iclass == CLS_LW) begin
            state_d = WB;
          end else begin
            pc_d    = pc_plus4;
            state_d = FETCH;
          end
        end else if (wait_q == TIMEOUT_LAST) begin
          state_d = HALT;
          fault_d = FAULT_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WB: begin
        pc_d    = pc_plus4;
        wait_d  = 8'd0;
        state_d = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // Registered strobes follow the state being entered
  always_comb begin
    imem_req_d = (state_d == FETCH);
    alu_src_d  = (state_d == EXEC) && ((iclass == CLS_LW) || (iclass == CLS_SW));
    reg_we_d   = (state_d == WB);
    wb_sel_d   = (state_d == WB) && (iclass == CLS_LW);
    dmem_re_d  = (state_d == MEM) && (iclass == CLS_LW);
    dmem_we_d  = (state_d == MEM) && (iclass == CLS_SW);
    halted_d   = (state_d == HALT);
  end

  // Sequencer state and output registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 32'd0;
      wait_q     <= 8'd0;
      fault_q    <= FAULT_NONE;
      imem_req_q <= 1'b0;
      alu_src_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      wb_sel_q   <= 1'b0;
      dmem_re_q  <= 1'b0;
      dmem_we_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      wait_q     <= wait_d;
      fault_q    <= fault_d;
      imem_req_q <= imem_req_d;
      alu_src_q  <= alu_src_d;
      reg_we_q   <= reg_we_d;
      wb_sel_q   <= wb_sel_d;
      dmem_re_q  <= dmem_re_d;
      dmem_we_q  <= dmem_we_d;
      halted_q   <= halted_d;
    end
  end

  assign pc       = pc_q;
  assign imem_req = imem_req_q;
  assign alu_src  = alu_src_q;
  assign reg_we   = reg_we_q;
  assign wb_sel   = wb_sel_q;
  assign dmem_re  = dmem_re_q;
  assign dmem_we  = dmem_we_q;
  assign halted   = halted_q;
  assign fault    = fault_q;

`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] retired_count_q, retired_count_d;
  logic        retire;

  // Instruction completion points and saturating counter increments
  always_comb begin
    retire = (state_q == WB) ||
             ((state_q == EXEC) && (iclass == CLS_BEQ)) ||
             ((state_q == MEM) && (iclass == CLS_SW) && dmem_done);
    cycle_count_d   = cycle_count_q;
    retired_count_d = retired_count_q;
    if ((state_q != HALT) && (cycle_count_q != 32'hFFFF_FFFF)) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end
    if (retire && (retired_count_q != 32'hFFFF_FFFF)) begin
      retired_count_d = retired_count_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count_q   <= 32'd0;
      retired_count_q <= 32'd0;
    end else begin
      cycle_count_q   <= cycle_count_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign cycle_count   = cycle_count_q;
  assign retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a table of single-instruction vectors
// with hand-computed PC, latency and strobe expectations, followed by
// hand-written sequences for illegal instructions, timeouts and reset.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [5:0]  alu_opcode;
  logic [4:0]  alu_shamt;
  logic [5:0]  alu_funct;
  logic        alu_zero;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] imm;
  logic        alu_src;
  logic        reg_we;
  logic        wb_sel;
  logic        dmem_re, dmem_we;
  logic        dmem_ready;
  logic        halted;
  logic [1:0]  fault;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] cycle_count, retired_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  alu_sequencer #(
    .RESET_PC    (32'h0000_0100),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_ready    (imem_ready),
    .instr         (instr),
    .pc            (pc),
    .alu_opcode    (alu_opcode),
    .alu_shamt     (alu_shamt),
    .alu_funct     (alu_funct),
    .alu_zero      (alu_zero),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rd_addr       (rd_addr),
    .imm           (imm),
    .alu_src       (alu_src),
    .reg_we        (reg_we),
    .wb_sel        (wb_sel),
    .dmem_re       (dmem_re),
    .dmem_we       (dmem_we),
    .dmem_ready    (dmem_ready),
    .halted        (halted),
`ifdef SEQ_PERF_COUNTERS_EN
    .cycle_count   (cycle_count),
    .retired_count (retired_count),
`endif
    .fault         (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          delay;   // dmem strobe cycles before ready is given
    logic [31:0] pc;      // expected pc when fetch resumes
    int          idle;    // cycles with imem_req low after acceptance
    int          we;      // reg_we pulses
    logic        wbsel;
    logic [4:0]  dest;
    int          strb;    // cycles with a dmem strobe high
    logic        src;     // alu_src seen high
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    alu_zero   = 1'b0;
    instr      = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for imem_req at a falling edge
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_req: imem_req never rose");
    end
  endtask

  // Present one instruction and record everything until fetch resumes
  task automatic run_vec(input int k);
    bit   ok, back;
    int   idle, we, strb;
    logic wbs, src;
    logic [4:0] dst;
    vec_t v;
    v = vecs[k];
    idle = 0; we = 0; strb = 0; wbs = 1'b0; src = 1'b0; dst = 5'd0; back = 1'b0;
    wait_req(ok);
    if (!ok) return;
    alu_zero   = v.zero;
    instr      = v.instr;
    imem_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      if (imem_req === 1'b1) begin
        back = 1'b1;
        break;
      end
      idle++;
      if (alu_src === 1'b1) src = 1'b1;
      if (reg_we === 1'b1) begin
        we++;
        wbs = wb_sel;
        dst = wb_sel ? rt_addr : rd_addr;
      end
      if (dmem_re === 1'b1 || dmem_we === 1'b1) begin
        strb++;
        if (strb > v.delay) dmem_ready = 1'b1;
      end
    end
    chk($sformatf("v%0d fetch_resumed", k), 32'(back), 32'd1);
    chk($sformatf("v%0d pc", k), pc, v.pc);
    chk($sformatf("v%0d idle_cycles", k), 32'(idle), 32'(v.idle));
    chk($sformatf("v%0d reg_we_pulses", k), 32'(we), 32'(v.we));
    chk($sformatf("v%0d dmem_strobe_cycles", k), 32'(strb), 32'(v.strb));
    chk($sformatf("v%0d alu_src", k), 32'(src), 32'(v.src));
    if (v.we > 0) begin
      chk($sformatf("v%0d wb_sel", k), 32'(wbs), 32'(v.wbsel));
      chk($sformatf("v%0d dest", k), 32'(dst), 32'(v.dest));
    end
    chk($sformatf("v%0d halted", k), 32'(halted), 32'd0);
    chk($sformatf("v%0d fault", k), 32'(fault), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt, we_seen;

    //               instr          z     dly pc            idle we wbsel dest  strb src
    vecs[0] = '{32'h0022_1820, 1'b0, 0, 32'h0000_0104, 3, 1, 1'b0, 5'd3, 0, 1'b0}; // ADD rd=3
    vecs[1] = '{32'h8C43_0008, 1'b0, 2, 32'h0000_0108, 6, 1, 1'b1, 5'd3, 3, 1'b1}; // LW, 2 waits
    vecs[2] = '{32'hAC43_0004, 1'b0, 3, 32'h0000_010C, 6, 0, 1'b0, 5'd0, 4, 1'b1}; // SW, ready at limit
    vecs[3] = '{32'h1000_FFC0, 1'b1, 0, 32'h0000_0010, 2, 0, 1'b0, 5'd0, 0, 1'b0}; // BEQ back to 0x10
    vecs[4] = '{32'h1000_FFFF, 1'b1, 0, 32'h0000_0010, 2, 0, 1'b0, 5'd0, 0, 1'b0}; // BEQ taken, self
    vecs[5] = '{32'h1000_FFFF, 1'b0, 0, 32'h0000_0014, 2, 0, 1'b0, 5'd0, 0, 1'b0}; // BEQ not taken
    vecs[6] = '{32'h0022_0022, 1'b0, 0, 32'h0000_0018, 3, 1, 1'b0, 5'd0, 0, 1'b0}; // SUB rd=0
    vecs[7] = '{32'h0004_21C0, 1'b0, 0, 32'h0000_001C, 3, 1, 1'b0, 5'd4, 0, 1'b0}; // SLL rd=4
    vecs[8] = '{32'h8C45_0000, 1'b0, 0, 32'h0000_0020, 4, 1, 1'b1, 5'd5, 1, 1'b1}; // LW no wait

    // Reset state, then request one cycle after release
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0; instr = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst pc", pc, 32'h0000_0100);
    chk("rst imem_req", 32'(imem_req), 32'd0);
    chk("rst strobes", 32'({reg_we, dmem_re, dmem_we}), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst imem_req", 32'(imem_req), 32'd1);

    for (int k = 0; k < 9; k++) run_vec(k);

    // Illegal opcode: halt, pc frozen, later fetch handshakes ignored
    wait_req(ok);
    instr = 32'hFC00_0000;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("illop halted", 32'(halted), 32'd1);
    chk("illop fault", 32'(fault), 32'd1);
    chk("illop pc", pc, 32'h0000_0020);
    chk("illop strobes", 32'({imem_req, reg_we, dmem_re, dmem_we}), 32'd0);
    instr = 32'h0022_1820;
    imem_ready = 1'b1;
    we_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (reg_we === 1'b1 || imem_req === 1'b1) we_seen++;
    end
    imem_ready = 1'b0;
    chk("illop ignore_fetch", 32'(we_seen), 32'd0);
    chk("illop still_halted", 32'(halted), 32'd1);
    chk("illop pc_frozen", pc, 32'h0000_0020);

    // Illegal R-type funct
    do_reset();
    wait_req(ok);
    instr = 32'h0000_0001;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("illfn halted", 32'(halted), 32'd1);
    chk("illfn fault", 32'(fault), 32'd1);
    chk("illfn pc", pc, 32'h0000_0100);

    // SW with dmem never ready: four strobe cycles then timeout fault
    do_reset();
    wait_req(ok);
    instr = 32'hAC43_0004;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (dmem_we === 1'b1) cnt++;
    end
    chk("memto dmem_we_cycles", 32'(cnt), 32'd4);
    chk("memto halted", 32'(halted), 32'd1);
    chk("memto fault", 32'(fault), 32'd2);
    chk("memto dmem_we_low", 32'(dmem_we), 32'd0);
    chk("memto pc", pc, 32'h0000_0100);

    // Fetch with imem never ready: four request cycles then timeout fault
    do_reset();
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (imem_req === 1'b1) cnt++;
    end
    chk("fetchto imem_req_cycles", 32'(cnt), 32'd4);
    chk("fetchto halted", 32'(halted), 32'd1);
    chk("fetchto fault", 32'(fault), 32'd2);

    // Reset in the middle of a SW memory handshake
    do_reset();
    chk("midrst fault_cleared", 32'(fault), 32'd0);
    wait_req(ok);
    instr = 32'hAC43_0004;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10 && cnt < 2; c++) begin
      @(negedge clk);
      if (dmem_we === 1'b1) cnt++;
    end
    chk("midrst reached_mem", 32'(cnt), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst pc", pc, 32'h0000_0100);
    chk("midrst dmem_we", 32'(dmem_we), 32'd0);
    chk("midrst halted", 32'(halted), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst refetch", 32'(imem_req), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multicycle control FSM for the soft processor. It fetches instructions, decodes the fields, and drives opcode/shamt/funct to the ALU. It sequences data-memory access and register writeback, and updates the PC.
Sits between instruction memory, the register file, the ALU and data memory. It is the only block that raises register-write and memory strobes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 255, max cycles waiting on imem/dmem ready before fault halt (8-bit counter; legal range 1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  instruction fetch request, held until imem_ready
imem_ready  in  1  instr valid this cycle
instr  in  32  fetched instruction word
pc  out  32  current PC (fetch address)
alu_opcode  out  6  instr[31:26] to ALU
alu_shamt  out  5  instr[10:6] to ALU
alu_funct  out  6  instr[5:0] to ALU
alu_zero  in  1  ALU diff == 0 (BEQ compare)
rs_addr, rt_addr, rd_addr  out  5 each  register file addresses
imm  out  32  sign-extended instr[15:0]
alu_src  out  1  0: in2=rt data, 1: in2=imm
reg_we  out  1  register-file write strobe, one cycle
wb_sel  out  1  0: ALU result, 1: dmem data
dmem_re, dmem_we  out  1 each  data-memory strobes, held until dmem_ready
dmem_ready  in  1  data-memory access complete
halted  out  1  sequencer stopped
fault  out  2  00 none, 01 illegal instr, 10 memory timeout

Behaviour:
- Reset (rst=1 at clk edge): state=FETCH, pc=RESET_PC, IR=0. All strobes, halted and fault are 0. rst has priority over every other event, including mid-handshake.
- States: FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH}; MEM -> {WB, FETCH}; WB -> FETCH; any state -> HALT on fault. HALT is exited only by rst.
- FETCH: imem_req=1. On imem_ready, latch IR=instr and go to DECODE. Otherwise stay and increment the wait counter.
- DECODE: drive the field outputs from IR. Legal opcodes: 000000 with funct in {100000, 100010, 100100, 100101, 000010, 000000}; 100011 LW; 101011 SW; 000100 BEQ. Anything else -> HALT, fault=01. pc is not advanced.
- EXEC (1 cycle): alu_src=1 for LW/SW, 0 otherwise.
  - R-type: go to WB.
  - LW/SW: go to MEM.
  - BEQ: if alu_zero, pc <= pc + 4 + (imm << 2); else pc <= pc + 4. Then go to FETCH.
- MEM: LW asserts dmem_re, SW asserts dmem_we, held until dmem_ready. Then LW goes to WB; SW sets pc <= pc + 4 and goes to FETCH.
- WB: reg_we=1 for exactly one cycle. wb_sel=1 for LW, 0 for R-type. Destination is rd for R-type, rt for LW. pc <= pc + 4, then FETCH.
- Writes to register 0: reg_we is still pulsed; the register file ignores address 0.
- Latency from imem_ready to the next imem_req (zero-wait memory):
  - R-type: 3 cycles
  - LW: 4 cycles (wait states add 1:1)
  - SW: 3 cycles
  - BEQ: 2 cycles
- PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal and silent.
- Timeout: the wait counter clears on entry to FETCH and to MEM. If it reaches MEM_TIMEOUT without ready: HALT, fault=10, all strobes dropped the same cycle.
- A ready arriving in the same cycle the counter hits the limit wins; no fault is raised.
- HALT: halted=1, all strobes 0, pc frozen.

Optional Feature:
SEQ_PERF_COUNTERS_EN
- Defined: adds output ports cycle_count[31:0] and retired_count[31:0].
  - cycle_count increments every non-HALT cycle.
  - retired_count increments on each instruction completion (WB exit, SW MEM exit, BEQ EXEC exit).
  - Both clear on rst and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent. Core behaviour is identical.

Decomposition:
- Shared package seq_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ) and funct constants (F_ADD, F_SUB, F_AND, F_OR, F_SRL, F_SLL), for use by both the ALU and this block;
  - state encoding (3-bit localparams for FETCH, DECODE, EXEC, MEM, WB, HALT);
  - fault codes.
- One sub-module: instr_decoder, purely combinational. Maps IR to field outputs, imm, class (rtype/lw/sw/beq) and legal flag. The FSM and PC logic remain in alu_sequencer.

Test Plan:
- rst with RESET_PC=32'h100 -> pc=32'h100, imem_req=1 next cycle, reg_we=dmem_re=dmem_we=halted=0.
- ADD instr 32'h0022_1820, imem_ready=1 -> DECODE/EXEC/WB follow. reg_we pulses 1 cycle with rd_addr=3, wb_sel=0; pc=32'h104; next imem_req 3 cycles after ready.
- LW 32'h8C43_0008 with dmem_ready delayed 2 cycles -> dmem_re held 3 cycles. WB then has wb_sel=1, rt_addr=3; pc += 4.
- BEQ 32'h1000_FFFF at pc=32'h10:
  - alu_zero=1 -> pc=32'h10.
  - alu_zero=0 -> pc=32'h14.
  - No reg_we in either case.
- Illegal opcode 6'b111111 -> halted=1, fault=01, pc unchanged, all strobes 0. Subsequent imem_ready is ignored until rst.
- SW with dmem_ready never asserted, MEM_TIMEOUT=4 -> dmem_we high 4 cycles, then halted=1, fault=10. rst asserted mid-MEM in a separate run -> FETCH at RESET_PC next cycle, dmem_we=0.
